mux_verilog: RTL and testbench
==============================

Name: mux_verilog

Overview:
- Registered 4:1 multiplexer. Selects one of four equal-width data inputs (a, b, c, d) using two select lines (s1 = MSB, s0 = LSB).
- The chosen value appears on out one clock after sampling.
- Used as a generic datapath/steering primitive. Single clock domain; no handshake.

Parameters:
- WIDTH, 1, bit width of each data input and of out (legal range 1..64).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- en   input  1  load enable; when 0, out and sel_q hold their value
- a    input  WIDTH  data input, selected when {s1,s0}=2'b00
- b    input  WIDTH  data input, selected when {s1,s0}=2'b01
- c    input  WIDTH  data input, selected when {s1,s0}=2'b10
- d    input  WIDTH  data input, selected when {s1,s0}=2'b11
- s0   input  1  select LSB
- s1   input  1  select MSB
- out  output WIDTH  registered mux result
- sel_q output 2  registered copy of {s1,s0} that produced the current out

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high.
- Combinational select, fully decoded:
  - {s1,s0}=00 -> a
  - 01 -> b
  - 10 -> c
  - 11 -> d
  - No latches. Default branch drives a (never reached for 0/1 selects).
- Register update on each rising clk edge:
  - rst=1: out <= 0 (all WIDTH bits), sel_q <= 2'b00. Reset has priority over en.
  - rst=0, en=1: out <= selected input, sel_q <= {s1,s0}.
  - rst=0, en=0: out and sel_q hold.
- Latency: exactly 1 cycle from input/select sampling to out. Throughput: 1 result per cycle.
- Simultaneous changes of data and select in the same cycle: the values present at the sampling edge decide the result. There is no glitch on out because it is registered.
- Reset asserted mid-stream: out is 0 from the edge after rst is sampled high. The first post-reset result appears one edge after rst is deasserted with en=1.
- Outputs are never X after the first reset edge, provided inputs are 0/1.
- Width rule: data passes bit-for-bit with no extension or truncation. All four inputs are exactly WIDTH bits.

Decomposition:
- Shared package mux_pkg:
  - Select encoding constants SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b10, SEL_D=2'b11.
  - typedef sel_t (logic [1:0]).
- One natural sub-module: mux4_core. Purely combinational WIDTH-parameterized 4:1 select, with inputs a/b/c/d and sel_t sel, output y.
- mux_verilog instantiates mux4_core and adds the en/rst output register and sel_q.

Test Plan:
- Reset: drive rst=1 for 2 cycles with a=1, en=1, sel=00 -> out=0, sel_q=00. Release rst -> out=1 after 1 edge.
- Select sweep (WIDTH=1): a=0, b=1, c=0, d=1 with en=1; step {s1,s0} through 00,01,10,11 one per cycle -> out sequence 0,1,0,1 each one cycle later; sel_q tracks 00,01,10,11.
- Toggling data: a, b, c, d toggling at periods 80/40/20/10 time units; s0 toggling every 80, s1 every 160 -> out at each edge equals the input picked by the previous-edge select. Check against a reference model every cycle.
- Enable hold: sel=10, c=1, en=1 for 1 cycle; then en=0, c=0, sel=00, a=0 -> out stays 1 and sel_q stays 10 while en=0.
- Reset priority: rst=1 and en=1 with d=1, sel=11 -> out=0. Mid-stream reset pulse of 1 cycle forces out=0 for exactly that edge.
- Width (WIDTH=8): a=8'h11, b=8'h22, c=8'h33, d=8'h44; sel 11 -> out=8'h44; sel 01 -> out=8'h22.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared select encoding for the registered 4:1 multiplexer.
package mux_pkg;

   typedef logic [1:0] sel_t;

   localparam sel_t SEL_A = 2'b00;
   localparam sel_t SEL_B = 2'b01;
   localparam sel_t SEL_C = 2'b10;
   localparam sel_t SEL_D = 2'b11;

endpackage

// File: rtl/mux4_core.sv
// Purely combinational, fully decoded WIDTH-bit 4:1 select.
module mux4_core
   import mux_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   input  sel_t             sel,
   output logic [WIDTH-1:0] y
);

   // Default to a first so no path can infer a latch.
   always_comb begin
      y = a;
      case (sel)
         SEL_A:   y = a;
         SEL_B:   y = b;
         SEL_C:   y = c;
         SEL_D:   y = d;
         default: y = a;
      endcase
   end

endmodule

// File: rtl/mux_verilog.sv
// Registered 4:1 multiplexer: one-cycle latency, load enable, synchronous reset.
module mux_verilog
   import mux_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   input  logic             s0,
   input  logic             s1,
   output logic [WIDTH-1:0] out,
   output logic [1:0]       sel_q
);

   sel_t             selIn;
   logic [WIDTH-1:0] muxY;

   assign selIn = {s1, s0};

   mux4_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .a  (a),
      .b  (b),
      .c  (c),
      .d  (d),
      .sel(selIn),
      .y  (muxY)
   );

   // Reset wins over enable; sel_q always records the select that produced out.
   always_ff @(posedge clk) begin
      if (rst) begin
         out   <= '0;
         sel_q <= SEL_A;
      end else if (en) begin
         out   <= muxY;
         sel_q <= selIn;
      end
   end

endmodule

// File: tb/tb_mux_verilog.sv
// Scoreboard bench driving an 8-bit and a 1-bit mux_verilog with shared controls.
module tb_mux_verilog;

   typedef struct {
      logic [7:0] out;
      logic [1:0] sel;
   } expect_t;

   logic       clk;
   logic       rst;
   logic       en;
   logic       s0;
   logic       s1;
   logic [7:0] a;
   logic [7:0] b;
   logic [7:0] c;
   logic [7:0] d;
   logic [7:0] outW;
   logic [1:0] selW;
   logic [0:0] outN;
   logic [1:0] selN;

   int tests;
   int fails;

   expect_t    sb[$];
   logic [7:0] modelOut;
   logic [1:0] modelSel;

   mux_verilog #(.WIDTH(8)) dutWide (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .a    (a),
      .b    (b),
      .c    (c),
      .d    (d),
      .s0   (s0),
      .s1   (s1),
      .out  (outW),
      .sel_q(selW)
   );

   mux_verilog #(.WIDTH(1)) dutNarrow (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .a    (a[0:0]),
      .b    (b[0:0]),
      .c    (c[0:0]),
      .d    (d[0:0]),
      .s0   (s0),
      .s1   (s1),
      .out  (outN),
      .sel_q(selN)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] refPick(input logic [1:0] sel, input logic [7:0] av,
                                          input logic [7:0] bv, input logic [7:0] cv,
                                          input logic [7:0] dv);
      case (sel)
         2'b00:   return av;
         2'b01:   return bv;
         2'b10:   return cv;
         default: return dv;
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one cycle at the falling edge, push the expected result, compare after the rising edge.
   task automatic applyStimulus(input string tag, input logic r, input logic e,
                                input logic [1:0] sel, input logic [7:0] av,
                                input logic [7:0] bv, input logic [7:0] cv,
                                input logic [7:0] dv);
      expect_t ex;
      @(negedge clk);
      rst = r;
      en  = e;
      {s1, s0} = sel;
      a = av;
      b = bv;
      c = cv;
      d = dv;
      if (r) begin
         modelOut = 8'h00;
         modelSel = 2'b00;
      end else if (e) begin
         modelOut = refPick(sel, av, bv, cv, dv);
         modelSel = sel;
      end
      ex.out = modelOut;
      ex.sel = modelSel;
      sb.push_back(ex);
      @(posedge clk);
      #1;
      ex = sb.pop_front();
      checkOutput({tag, " outW"}, outW, ex.out);
      checkOutput({tag, " selW"}, {6'b0, selW}, {6'b0, ex.sel});
      checkOutput({tag, " outN"}, {7'b0, outN}, {7'b0, ex.out[0]});
      checkOutput({tag, " selN"}, {6'b0, selN}, {6'b0, ex.sel});
   endtask

   initial begin
      logic [7:0] ta, tb, tc, td;
      tests    = 0;
      fails    = 0;
      modelOut = 8'h00;
      modelSel = 2'b00;
      rst = 1'b1;
      en  = 1'b1;
      {s1, s0} = 2'b00;
      a = 8'h00;
      b = 8'h00;
      c = 8'h00;
      d = 8'h00;

      // Reset for two cycles with a=1, then release
      applyStimulus("reset0", 1'b1, 1'b1, 2'b00, 8'h01, 8'h00, 8'h00, 8'h00);
      applyStimulus("reset1", 1'b1, 1'b1, 2'b00, 8'h01, 8'h00, 8'h00, 8'h00);
      applyStimulus("release", 1'b0, 1'b1, 2'b00, 8'h01, 8'h00, 8'h00, 8'h00);

      // Select sweep a=0 b=1 c=0 d=1
      for (int i = 0; i < 4; i++)
         applyStimulus($sformatf("sweep%0d", i), 1'b0, 1'b1, 2'(i), 8'h00, 8'h01, 8'h00, 8'h01);

      // Toggling data: a/b/c/d toggle every 8/4/2/1 cycles, s0 every 8, s1 every 16
      for (int k = 0; k < 32; k++) begin
         ta = {8{1'((k / 8) % 2)}}  ^ 8'h5A;
         tb = {8{1'((k / 4) % 2)}}  ^ 8'hC3;
         tc = {8{1'((k / 2) % 2)}}  ^ 8'h0F;
         td = {8{1'(k % 2)}}        ^ 8'h96;
         applyStimulus($sformatf("toggle%0d", k), 1'b0, 1'b1,
                       {1'((k / 16) % 2), 1'((k / 8) % 2)}, ta, tb, tc, td);
      end

      // Enable hold
      applyStimulus("holdLoad", 1'b0, 1'b1, 2'b10, 8'hA5, 8'h00, 8'hFF, 8'h00);
      applyStimulus("hold0",    1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
      applyStimulus("hold1",    1'b0, 1'b0, 2'b00, 8'h00, 8'h7E, 8'h00, 8'h00);

      // Reset priority over enable
      applyStimulus("rstPrio",  1'b1, 1'b1, 2'b11, 8'h00, 8'h00, 8'h00, 8'hFF);

      // Mid-stream one-cycle reset pulse
      applyStimulus("stream0",  1'b0, 1'b1, 2'b11, 8'h00, 8'h00, 8'h00, 8'hFF);
      applyStimulus("pulse",    1'b1, 1'b1, 2'b11, 8'h00, 8'h00, 8'h00, 8'hFF);
      applyStimulus("stream1",  1'b0, 1'b1, 2'b11, 8'h00, 8'h00, 8'h00, 8'hFF);

      // Width check
      applyStimulus("width11",  1'b0, 1'b1, 2'b11, 8'h11, 8'h22, 8'h33, 8'h44);
      applyStimulus("width01",  1'b0, 1'b1, 2'b01, 8'h11, 8'h22, 8'h33, 8'h44);
      applyStimulus("width10",  1'b0, 1'b1, 2'b10, 8'h11, 8'h22, 8'h33, 8'h44);
      applyStimulus("width00",  1'b0, 1'b1, 2'b00, 8'h11, 8'h22, 8'h33, 8'h44);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
